// File: rtl/reset_seq_pkg.sv
// Shared types and defaults for the SoC reset sequencer: the fixed state encoding,
// the default delay values and a range check for the delay counter.
package reset_seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_HOLD        = 3'd0,
        ST_PERIPH_WAIT = 3'd1,
        ST_MEM_INIT    = 3'd2,
        ST_CPU_WAIT    = 3'd3,
        ST_RUN         = 3'd4
    } seq_state_e;

    localparam int unsigned DEF_HOLD_CYCLES  = 16;
    localparam int unsigned DEF_PERIPH_DELAY = 8;
    localparam int unsigned DEF_CPU_DELAY    = 4;
    localparam int unsigned DEF_INIT_TIMEOUT = 4096;
    localparam int unsigned DEF_CNT_W        = 16;

    // A delay is usable when it is at least one cycle and representable in width bits.
    function automatic bit delay_fits(input longint unsigned value, input int unsigned width);
        return (value >= 64'd1) && ((value >> width) == 64'd0);
    endfunction

endpackage

// File: rtl/seq_delay_counter.sv
// Saturating cycle counter with synchronous clear and a terminal-count compare
// against a limit that the owning FSM may change every cycle.
module seq_delay_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             at_limit
);

    logic [CNT_W-1:0] count_reg;

    // Holds at all-ones rather than wrapping, so a stalled compare can never re-fire.
    always_ff @(posedge clk) begin
        if (clear) begin
            count_reg <= '0;
        end else if (enable && !(&count_reg)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign at_limit = (count_reg == limit);

endmodule

// File: rtl/reset_sequencer.sv
// Releases peripheral, memory-init and CPU reset domains in order after the fabric
// reset, with a memory-init handshake, timeout flag and CPU-requested soft reset.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES  = DEF_HOLD_CYCLES,
    parameter int unsigned PERIPH_DELAY = DEF_PERIPH_DELAY,
    parameter int unsigned CPU_DELAY    = DEF_CPU_DELAY,
    parameter int unsigned INIT_TIMEOUT = DEF_INIT_TIMEOUT,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic               CLK,
    input  logic               FABRIC_RESET_N,
    input  logic               MEM_INIT_DONE,
    input  logic               SOFT_RST_REQ,
    output logic               PERIPH_RESET_N,
    output logic               MEM_INIT_REQ,
    output logic               CPU_RESET_N,
    output logic               SEQ_DONE,
    output logic               INIT_TIMEOUT_ERR,
    output logic [STATE_W-1:0] STATE
);

    function automatic longint unsigned delay_of(input int idx);
        case (idx)
            0:       return longint'(HOLD_CYCLES);
            1:       return longint'(PERIPH_DELAY);
            2:       return longint'(CPU_DELAY);
            default: return longint'(INIT_TIMEOUT);
        endcase
    endfunction

    for (genvar gi = 0; gi < 4; gi++) begin : g_delay_check
        if (!delay_fits(delay_of(gi), CNT_W)) begin : g_bad_delay
            $error("reset_sequencer: delay index %0d is zero or does not fit in CNT_W", gi);
        end
    end

    seq_state_e       state_reg, state_next;
    logic             periph_reset_n_reg, periph_reset_n_next;
    logic             mem_init_req_reg,   mem_init_req_next;
    logic             cpu_reset_n_reg,    cpu_reset_n_next;
    logic             seq_done_reg,       seq_done_next;
    logic             timeout_err_reg,    timeout_err_next;

    logic             cnt_clear;
    logic             cnt_clear_fsm;
    logic             cnt_enable;
    logic [CNT_W-1:0] cnt_limit;
    logic             cnt_at_limit;

    assign cnt_clear = !FABRIC_RESET_N || cnt_clear_fsm;

    seq_delay_counter #(
        .CNT_W (CNT_W)
    ) u_delay_counter (
        .clk      (CLK),
        .clear    (cnt_clear),
        .enable   (cnt_enable),
        .limit    (cnt_limit),
        .at_limit (cnt_at_limit)
    );

    always_ff @(posedge CLK) begin
        if (!FABRIC_RESET_N) begin
            state_reg          <= ST_HOLD;
            periph_reset_n_reg <= 1'b0;
            mem_init_req_reg   <= 1'b0;
            cpu_reset_n_reg    <= 1'b0;
            seq_done_reg       <= 1'b0;
            timeout_err_reg    <= 1'b0;
        end else begin
            state_reg          <= state_next;
            periph_reset_n_reg <= periph_reset_n_next;
            mem_init_req_reg   <= mem_init_req_next;
            cpu_reset_n_reg    <= cpu_reset_n_next;
            seq_done_reg       <= seq_done_next;
            timeout_err_reg    <= timeout_err_next;
        end
    end

    // HOLD is entered with the counter at zero and its first counted edge is the
    // entry-following one, so it compares against the full count; the other waits
    // are measured from their entry edge and therefore compare against count-1.
    always_comb begin
        state_next          = state_reg;
        periph_reset_n_next = periph_reset_n_reg;
        mem_init_req_next   = mem_init_req_reg;
        cpu_reset_n_next    = cpu_reset_n_reg;
        seq_done_next       = seq_done_reg;
        timeout_err_next    = timeout_err_reg;
        cnt_clear_fsm       = 1'b0;
        cnt_enable          = 1'b0;
        cnt_limit           = '0;

        case (state_reg)
            ST_HOLD: begin
                cnt_limit = CNT_W'(HOLD_CYCLES);
                if (cnt_at_limit) begin
                    periph_reset_n_next = 1'b1;
                    state_next          = ST_PERIPH_WAIT;
                    cnt_clear_fsm       = 1'b1;
                end else begin
                    cnt_enable = 1'b1;
                end
            end

            ST_PERIPH_WAIT: begin
                cnt_limit = CNT_W'(PERIPH_DELAY - 1);
                if (cnt_at_limit) begin
                    mem_init_req_next = 1'b1;
                    state_next        = ST_MEM_INIT;
                    cnt_clear_fsm     = 1'b1;
                end else begin
                    cnt_enable = 1'b1;
                end
            end

            ST_MEM_INIT: begin
                cnt_limit = CNT_W'(INIT_TIMEOUT - 1);
                // A done seen on the final timeout edge takes priority over the error.
                if (MEM_INIT_DONE) begin
                    mem_init_req_next = 1'b0;
                    state_next        = ST_CPU_WAIT;
                    cnt_clear_fsm     = 1'b1;
                end else if (cnt_at_limit) begin
                    mem_init_req_next = 1'b0;
                    timeout_err_next  = 1'b1;
                    state_next        = ST_CPU_WAIT;
                    cnt_clear_fsm     = 1'b1;
                end else begin
                    cnt_enable = 1'b1;
                end
            end

            ST_CPU_WAIT: begin
                cnt_limit = CNT_W'(CPU_DELAY - 1);
                if (cnt_at_limit) begin
                    cpu_reset_n_next = 1'b1;
                    seq_done_next    = 1'b1;
                    state_next       = ST_RUN;
                    cnt_clear_fsm    = 1'b1;
                end else begin
                    cnt_enable = 1'b1;
                end
            end

            ST_RUN: begin
                // Soft reset keeps the timeout flag so firmware can still inspect it.
                if (SOFT_RST_REQ) begin
                    periph_reset_n_next = 1'b0;
                    mem_init_req_next   = 1'b0;
                    cpu_reset_n_next    = 1'b0;
                    seq_done_next       = 1'b0;
                    state_next          = ST_HOLD;
                    cnt_clear_fsm       = 1'b1;
                end
            end

            default: begin
                periph_reset_n_next = 1'b0;
                mem_init_req_next   = 1'b0;
                cpu_reset_n_next    = 1'b0;
                seq_done_next       = 1'b0;
                state_next          = ST_HOLD;
                cnt_clear_fsm       = 1'b1;
            end
        endcase
    end

    assign PERIPH_RESET_N   = periph_reset_n_reg;
    assign MEM_INIT_REQ     = mem_init_req_reg;
    assign CPU_RESET_N      = cpu_reset_n_reg;
    assign SEQ_DONE         = seq_done_reg;
    assign INIT_TIMEOUT_ERR = timeout_err_reg;
    assign STATE            = state_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: expected outputs come from an event-time
// model (release edges computed arithmetically from T0 and the first DONE edge).
module tb_reset_sequencer;

    localparam int H     = 16;
    localparam int P     = 8;
    localparam int C     = 4;
    localparam int TO    = 64;
    localparam int NEVER = 1000000;

    logic       CLK = 1'b0;
    logic       FABRIC_RESET_N = 1'b0;
    logic       MEM_INIT_DONE = 1'b0;
    logic       SOFT_RST_REQ = 1'b0;
    logic       PERIPH_RESET_N;
    logic       MEM_INIT_REQ;
    logic       CPU_RESET_N;
    logic       SEQ_DONE;
    logic       INIT_TIMEOUT_ERR;
    logic [2:0] STATE;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    bit err_sticky = 1'b0;

    typedef struct packed {
        logic [2:0] st;
        logic       periph;
        logic       req;
        logic       cpu;
        logic       sdone;
        logic       err;
    } obs_t;

    reset_sequencer #(
        .HOLD_CYCLES  (H),
        .PERIPH_DELAY (P),
        .CPU_DELAY    (C),
        .INIT_TIMEOUT (TO),
        .CNT_W        (16)
    ) dut (
        .CLK              (CLK),
        .FABRIC_RESET_N   (FABRIC_RESET_N),
        .MEM_INIT_DONE    (MEM_INIT_DONE),
        .SOFT_RST_REQ     (SOFT_RST_REQ),
        .PERIPH_RESET_N   (PERIPH_RESET_N),
        .MEM_INIT_REQ     (MEM_INIT_REQ),
        .CPU_RESET_N      (CPU_RESET_N),
        .SEQ_DONE         (SEQ_DONE),
        .INIT_TIMEOUT_ERR (INIT_TIMEOUT_ERR),
        .STATE            (STATE)
    );

    always #5 CLK = ~CLK;

    // Expected outputs after edge k for a sequence starting at t0, where DONE is
    // sampled high on every edge >= done_at.
    function automatic obs_t model(input int k, input int t0, input int done_at, input bit err_in);
        obs_t e;
        int   pr, rr, acc, fin;
        bit   timed_out;
        pr  = t0 + H;
        rr  = pr + P;
        acc = (done_at > rr + 1) ? done_at : rr + 1;
        if (acc <= rr + TO) begin
            fin = acc;
            timed_out = 1'b0;
        end else begin
            fin = rr + TO;
            timed_out = 1'b1;
        end
        if (k < pr)           e.st = 3'd0;
        else if (k < rr)      e.st = 3'd1;
        else if (k < fin)     e.st = 3'd2;
        else if (k < fin + C) e.st = 3'd3;
        else                  e.st = 3'd4;
        e.periph = (k >= pr);
        e.req    = (k >= rr) && (k < fin);
        e.cpu    = (k >= fin + C);
        e.sdone  = e.cpu;
        e.err    = err_in | (timed_out && (k >= fin));
        return e;
    endfunction

    function automatic obs_t sample();
        return {STATE, PERIPH_RESET_N, MEM_INIT_REQ, CPU_RESET_N, SEQ_DONE, INIT_TIMEOUT_ERR};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
        edge_n++;
    endtask

    task automatic check_invariants();
        checks++;
        if (CPU_RESET_N && !PERIPH_RESET_N) begin
            errors++;
            $display("FAIL inv_cpu_periph edge %0d: cpu=%b periph=%b, cpu released needs periph released",
                     edge_n, CPU_RESET_N, PERIPH_RESET_N);
        end
        checks++;
        if (MEM_INIT_REQ && STATE != 3'd2) begin
            errors++;
            $display("FAIL inv_req_state edge %0d: req=1 with state=%0d, required state 2", edge_n, STATE);
        end
        checks++;
        if (SEQ_DONE !== (STATE == 3'd4)) begin
            errors++;
            $display("FAIL inv_seq_done edge %0d: seq_done=%b state=%0d", edge_n, SEQ_DONE, STATE);
        end
    endtask

    task automatic fabric_reset(input int n);
        FABRIC_RESET_N = 1'b0;
        for (int i = 0; i < n; i++) begin
            MEM_INIT_DONE = 1'($urandom_range(0, 1));
            SOFT_RST_REQ  = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if (sample() !== obs_t'(0)) begin
                errors++;
                $display("FAIL reset_values cycle %0d: got %b, expected %b", i, sample(), obs_t'(0));
            end
        end
        FABRIC_RESET_N = 1'b1;
        MEM_INIT_DONE  = 1'b0;
        SOFT_RST_REQ   = 1'b0;
        edge_n         = -1;
        err_sticky     = 1'b0;
    endtask

    // Runs edges edge_n+1..last against the model; soft_at (if >= 0) must fall in RUN.
    task automatic run_checked(input int t0_in, input int done_in, input int soft_at,
                               input int done_after, input int last, input bit noise);
        int   t0;
        int   done_at;
        bit   err_in;
        obs_t e, prev, obs;
        t0      = t0_in;
        done_at = done_in;
        err_in  = err_sticky;
        for (int k = edge_n + 1; k <= last; k++) begin
            prev = model(k - 1, t0, done_at, err_in);
            if (k == soft_at) begin
                t0           = k + 1;
                done_at      = done_after;
                err_in       = err_sticky;
                SOFT_RST_REQ = 1'b1;
            end else if (noise && prev.st != 3'd4) begin
                SOFT_RST_REQ = 1'($urandom_range(0, 1));
            end else begin
                SOFT_RST_REQ = 1'b0;
            end
            MEM_INIT_DONE = (k >= done_at);
            tick();
            e   = model(k, t0, done_at, err_in);
            obs = sample();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL outputs edge %0d: got st=%0d pr=%b rq=%b cpu=%b dn=%b err=%b, expected st=%0d pr=%b rq=%b cpu=%b dn=%b err=%b",
                         k, obs.st, obs.periph, obs.req, obs.cpu, obs.sdone, obs.err,
                         e.st, e.periph, e.req, e.cpu, e.sdone, e.err);
            end
            err_sticky = e.err;
            check_invariants();
        end
        SOFT_RST_REQ  = 1'b0;
        MEM_INIT_DONE = 1'b0;
    endtask

    task automatic test_reset();
        fabric_reset(5);
        $display("test_reset: 5 cycles with random DONE/SOFT held in reset");
    endtask

    task automatic test_normal_boot();
        fabric_reset(3);
        run_checked(0, 30, -1, 0, 45, 1'b1);
        $display("test_normal_boot: done sampled at 30, soft noise outside RUN, edges 0..45");
    endtask

    task automatic test_timeout();
        int soft_at;
        fabric_reset(2);
        soft_at = 100 + int'($urandom_range(0, 5));
        run_checked(0, NEVER, soft_at, soft_at + 1 + H + P + 5, soft_at + 1 + H + P + C + 20, 1'b1);
        $display("test_timeout: no DONE, timeout at 88, soft reset at %0d then replay", soft_at);
    endtask

    task automatic test_done_on_timeout_edge();
        fabric_reset(2);
        run_checked(0, 88, -1, 0, 100, 1'b0);
        $display("test_done_on_timeout_edge: DONE first sampled at 88");
    endtask

    task automatic test_soft_reset();
        fabric_reset(2);
        run_checked(0, 30, 50, 60, 110, 1'b0);
        $display("test_soft_reset: soft reset at 50, replay done sampled at 76");
    endtask

    task automatic test_fabric_mid();
        fabric_reset(2);
        run_checked(0, 40, -1, 0, 26, 1'b0);
        fabric_reset(3);
        run_checked(0, 29, -1, 0, 45, 1'b0);
        $display("test_fabric_mid: fabric reset at edge 27 during MEM_INIT, full restart");
    endtask

    task automatic test_done_early();
        fabric_reset(2);
        run_checked(0, 0, -1, 0, 40, 1'b0);
        $display("test_done_early: DONE high before REQ, accepted at 25");
    endtask

    task automatic test_random();
        int done_at, run_edge, soft_at, done_after;
        obs_t e;
        for (int it = 0; it < 6; it++) begin
            fabric_reset(int'($urandom_range(1, 4)));
            done_at  = int'($urandom_range(0, 100));
            run_edge = 0;
            for (int k = 0; k < 200; k++) begin
                e = model(k, 0, done_at, 1'b0);
                if (e.st == 3'd4) begin
                    run_edge = k;
                    break;
                end
            end
            soft_at    = run_edge + 1 + int'($urandom_range(0, 10));
            done_after = soft_at + int'($urandom_range(0, 100));
            run_checked(0, done_at, soft_at, done_after, soft_at + 1 + H + P + TO + C + 5, 1'b1);
            $display("test_random[%0d]: done_at=%0d soft_at=%0d done_after=%0d", it, done_at, soft_at, done_after);
        end
    endtask

    initial begin
        test_reset();
        test_normal_boot();
        test_timeout();
        test_done_on_timeout_edge();
        test_soft_reset();
        test_fabric_mid();
        test_done_early();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
